// File: rtl/multicycle_controller.sv
// Multicycle MIPS control unit: Moore FSM plus ALU decoder.
// Ports: clk, reset (async, high), op/funct/zero in; datapath controls and state out.
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       irwrite,
    output logic       regwrite,
    output logic       memwrite,
    output logic       iord,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] resultsrc,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11,
        LUIWB   = 4'd12
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_LUI  = 6'b001111;

    state_t     state_q;
    state_t     state_n;
    logic       pcwrite;
    logic       branch;
    logic       irw;
    logic       rw;
    logic       mw;
    logic [1:0] aluop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_n;
    end

    always_comb begin
        state_n   = FETCH;
        pcwrite   = 1'b0;
        branch    = 1'b0;
        irw       = 1'b0;
        rw        = 1'b0;
        mw        = 1'b0;
        iord      = 1'b0;
        regdst    = 1'b0;
        alusrca   = 1'b0;
        alusrcb   = 2'b00;
        resultsrc = 2'b00;
        pcsrc     = 2'b00;
        aluop     = 2'b00;
        case (state_q)
            FETCH: begin
                state_n = DECODE;
                alusrcb = 2'b01;
                irw     = 1'b1;
                pcwrite = 1'b1;
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW,
                    OP_SW:   state_n = MEMADR;
                    OP_RTYP: state_n = RTYPEEX;
                    OP_BEQ:  state_n = BEQEX;
                    OP_ADDI: state_n = ADDIEX;
                    OP_J:    state_n = JEX;
                    OP_LUI:  state_n = LUIWB;
                    default: state_n = FETCH;
                endcase
            end
            MEMADR: begin
                state_n = (op == OP_LW) ? MEMRD : MEMWR;
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD: begin
                state_n = MEMWB;
                iord    = 1'b1;
            end
            MEMWB: begin
                resultsrc = 2'b01;
                rw        = 1'b1;
            end
            MEMWR: begin
                iord = 1'b1;
                mw   = 1'b1;
            end
            RTYPEEX: begin
                state_n = RTYPEWB;
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            RTYPEWB: begin
                regdst = 1'b1;
                rw     = 1'b1;
            end
            BEQEX: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            ADDIEX: begin
                state_n = ADDIWB;
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            ADDIWB: begin
                rw = 1'b1;
            end
            JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            LUIWB: begin
                resultsrc = 2'b10;
                rw        = 1'b1;
            end
            default: state_n = FETCH;
        endcase
    end

    // Write strobes are squashed while reset is held so nothing
    // commits in the FETCH state that reset forces.
    assign pcen     = ~reset & (pcwrite | (branch & zero));
    assign irwrite  = ~reset & irw;
    assign regwrite = ~reset & rw;
    assign memwrite = ~reset & mw;

    always_comb begin
        alucontrol = 3'b010;
        case (aluop)
            2'b00: alucontrol = 3'b010;
            2'b01: alucontrol = 3'b110;
            default: begin
                case (funct)
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default:   alucontrol = 3'b010;
                endcase
            end
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller: vector table, corner sequences
// and random instruction stream against a per-instruction model.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       pcen, irwrite, regwrite, memwrite;
    logic       iord, regdst, alusrca;
    logic [1:0] alusrcb, resultsrc, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pcen(pcen), .irwrite(irwrite), .regwrite(regwrite),
        .memwrite(memwrite), .iord(iord), .regdst(regdst),
        .alusrca(alusrca), .alusrcb(alusrcb), .resultsrc(resultsrc),
        .pcsrc(pcsrc), .alucontrol(alucontrol), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcwrite;
        logic       branch;
        logic       irwrite;
        logic       regwrite;
        logic       memwrite;
        logic       iord;
        logic       regdst;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] resultsrc;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
    } ctl_t;

    ctl_t ctl_tab [13];

    typedef int q_t[$];

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] funct;
        int         zm;
        int         cycles;
        bit         chk_alu;
        logic [2:0] alu;
    } vec_t;

    vec_t vt [15];

    task automatic fill_tab();
        for (int i = 0; i < 13; i++) ctl_tab[i] = '0;
        ctl_tab[0].alusrcb  = 2'b01;
        ctl_tab[0].irwrite  = 1'b1;
        ctl_tab[0].pcwrite  = 1'b1;
        ctl_tab[1].alusrcb  = 2'b11;
        ctl_tab[2].alusrca  = 1'b1;
        ctl_tab[2].alusrcb  = 2'b10;
        ctl_tab[3].iord     = 1'b1;
        ctl_tab[4].resultsrc = 2'b01;
        ctl_tab[4].regwrite = 1'b1;
        ctl_tab[5].iord     = 1'b1;
        ctl_tab[5].memwrite = 1'b1;
        ctl_tab[6].alusrca  = 1'b1;
        ctl_tab[6].aluop    = 2'b10;
        ctl_tab[7].regdst   = 1'b1;
        ctl_tab[7].regwrite = 1'b1;
        ctl_tab[8].alusrca  = 1'b1;
        ctl_tab[8].aluop    = 2'b01;
        ctl_tab[8].pcsrc    = 2'b01;
        ctl_tab[8].branch   = 1'b1;
        ctl_tab[9].alusrca  = 1'b1;
        ctl_tab[9].alusrcb  = 2'b10;
        ctl_tab[10].regwrite = 1'b1;
        ctl_tab[11].pcsrc   = 2'b10;
        ctl_tab[11].pcwrite = 1'b1;
        ctl_tab[12].resultsrc = 2'b10;
        ctl_tab[12].regwrite = 1'b1;
    endtask

    // State walk of one instruction, starting at FETCH.
    function automatic q_t build_seq(logic [5:0] o);
        q_t s;
        s.push_back(0);
        s.push_back(1);
        case (o)
            6'b100011: begin s.push_back(2); s.push_back(3); s.push_back(4); end
            6'b101011: begin s.push_back(2); s.push_back(5); end
            6'b000000: begin s.push_back(6); s.push_back(7); end
            6'b000100: s.push_back(8);
            6'b001000: begin s.push_back(9); s.push_back(10); end
            6'b000010: s.push_back(11);
            6'b001111: s.push_back(12);
            default: ;
        endcase
        return s;
    endfunction

    function automatic logic [2:0] alu_ref(logic [1:0] a, logic [5:0] f);
        if (a == 2'b00) return 3'b010;
        if (a == 2'b01) return 3'b110;
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic logic [19:0] exp_vec(int st, logic z, logic [5:0] f);
        ctl_t c;
        c = ctl_tab[st];
        return {c.pcwrite | (c.branch & z), c.irwrite, c.regwrite,
                c.memwrite, c.iord, c.regdst, c.alusrca, c.alusrcb,
                c.resultsrc, c.pcsrc, alu_ref(c.aluop, f), 4'(st)};
    endfunction

    function automatic logic [19:0] act_vec();
        return {pcen, irwrite, regwrite, memwrite, iord, regdst, alusrca,
                alusrcb, resultsrc, pcsrc, alucontrol, state};
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Leaves the DUT in FETCH, 1 time unit after a rising edge.
    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // zm: 0/1 fixed zero value, 2 random per cycle.
    task automatic run_instr(input string nm, input logic [5:0] o,
                             input logic [5:0] f, input int zm,
                             output int cyc, output logic [2:0] alu_ex);
        q_t seq;
        seq = build_seq(o);
        cyc = 0;
        alu_ex = 3'b000;
        op = o;
        funct = f;
        forever begin
            zero = (zm == 2) ? 1'($urandom_range(0, 1)) : 1'(zm);
            @(negedge clk);
            if (cyc < seq.size())
                chk($sformatf("%s c%0d", nm, cyc), 32'(act_vec()),
                    32'(exp_vec(seq[cyc], zero, f)));
            if (cyc == 2) alu_ex = alucontrol;
            cyc++;
            @(posedge clk);
            #1;
            if (state == 4'd0 || cyc >= 8) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         cyc;
        logic [2:0] ax;
        logic [5:0] ro, rf;
        logic [5:0] opl [7];
        logic [5:0] fnl [6];

        fill_tab();
        vt[0]  = '{"lw",    6'b100011, 6'd0,      0, 5, 1'b0, 3'b000};
        vt[1]  = '{"sw",    6'b101011, 6'd0,      0, 4, 1'b0, 3'b000};
        vt[2]  = '{"sub",   6'b000000, 6'b100010, 0, 4, 1'b1, 3'b110};
        vt[3]  = '{"slt",   6'b000000, 6'b101010, 0, 4, 1'b1, 3'b111};
        vt[4]  = '{"or",    6'b000000, 6'b100101, 0, 4, 1'b1, 3'b001};
        vt[5]  = '{"fx3f",  6'b000000, 6'b111111, 0, 4, 1'b1, 3'b010};
        vt[6]  = '{"add",   6'b000000, 6'b100000, 1, 4, 1'b1, 3'b010};
        vt[7]  = '{"and",   6'b000000, 6'b100100, 0, 4, 1'b1, 3'b000};
        vt[8]  = '{"beqz1", 6'b000100, 6'd0,      1, 3, 1'b0, 3'b000};
        vt[9]  = '{"beqz0", 6'b000100, 6'd0,      0, 3, 1'b0, 3'b000};
        vt[10] = '{"addi",  6'b001000, 6'b100010, 0, 4, 1'b0, 3'b000};
        vt[11] = '{"j",     6'b000010, 6'd0,      0, 3, 1'b0, 3'b000};
        vt[12] = '{"lui",   6'b001111, 6'd0,      0, 3, 1'b0, 3'b000};
        vt[13] = '{"op3f",  6'b111111, 6'd0,      1, 2, 1'b0, 3'b000};
        vt[14] = '{"op01",  6'b000001, 6'd0,      0, 2, 1'b0, 3'b000};

        // Reset state: FETCH controls with write strobes held low.
        @(negedge clk);
        chk("reset vec", 32'(act_vec()),
            32'(exp_vec(0, zero, funct) & ~20'hC0000));
        do_reset();

        foreach (vt[i]) begin
            run_instr(vt[i].name, vt[i].op, vt[i].funct, vt[i].zm, cyc, ax);
            chk({vt[i].name, " cycles"}, 32'(cyc), 32'(vt[i].cycles));
            if (vt[i].chk_alu)
                chk({vt[i].name, " alu"}, 32'(ax), 32'(vt[i].alu));
        end

        // Reset asserted in RTYPEEX aborts the instruction at once.
        op = 6'b000000;
        funct = 6'b100010;
        zero = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        chk("pre-reset state", 32'(state), 32'd6);
        reset = 1'b1;
        #1;
        chk("async reset", 32'(act_vec()),
            32'(exp_vec(0, zero, funct) & ~20'hC0000));
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk($sformatf("reset hold %0d", k), 32'(act_vec()),
                32'(exp_vec(0, zero, funct) & ~20'hC0000));
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post-reset fetch", 32'({pcen, irwrite, state}), 32'(6'b110000));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("post-reset decode", 32'({pcen, irwrite, state}), 32'(6'b000001));
        do_reset();

        // Random instruction stream.
        opl = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                6'b001000, 6'b000010, 6'b001111};
        fnl = '{6'b100000, 6'b100010, 6'b100100,
                6'b100101, 6'b101010, 6'b000000};
        for (int n = 0; n < 150; n++) begin
            int oi, fi;
            oi = int'($urandom_range(0, 7));
            fi = int'($urandom_range(0, 6));
            ro = (oi == 7) ? 6'($urandom) : opl[oi];
            rf = (fi == 6) ? 6'($urandom) : fnl[fi];
            run_instr($sformatf("rand%0d op%b", n, ro), ro, rf, 2, cyc, ax);
            chk($sformatf("rand%0d cycles", n), 32'(cyc),
                32'(build_seq(ro).size()));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
